feed_arbiter: RTL and testbench
===============================

# feed_arbiter

Message-granular round-robin arbiter that shares the single ITCH message parser between several independent feed byte streams. Each feed carries back-to-back frames: a 2-byte big-endian length L followed by L bytes (type + body). The block locks onto one feed for exactly one whole frame, passes its bytes through unmodified, then re-arbitrates. It sits between the per-feed receive paths and the parser's `in_byte/in_valid/in_ready` port.

## Interface
- `NUM_FEEDS`, default 4: number of feed inputs (≥2).
- `FEED_W`, default `$clog2(NUM_FEEDS)`: feed index width.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_byte` input NUM_FEEDS*8: feed i byte at bits [8i+7:8i].
- `in_valid` input NUM_FEEDS: per-feed byte valid.
- `in_ready` output NUM_FEEDS: per-feed byte accepted this cycle.
- `out_byte` output 8: byte to parser.
- `out_valid` output 1: `out_byte` valid.
- `out_ready` input 1: parser accepts (tied high by the current parser; the block must honour it anyway).
- `out_feed` output FEED_W: index of the feed currently granted.
- `out_sof` output 1: current transfer is the frame's first length byte.
- `out_eof` output 1: current transfer is the frame's last byte.
- `busy` output 1: a frame is locked (state ≠ IDLE).

## Operation
- Transfer on a port = valid && ready in the same cycle.
- States: IDLE, LEN_HI, LEN_LO, BODY.
- IDLE: `in_ready`=0, `out_valid`=0. If any `in_valid`, select the first requesting feed searching from `(last_grant+1) mod NUM_FEEDS` upward with wrap; register it into `grant` and `last_grant`; go to LEN_HI. No byte moves in the IDLE cycle.
- LEN_HI/LEN_LO/BODY: combinational pass-through of the granted feed: `out_byte`=`in_byte[grant]`, `out_valid`=`in_valid[grant]`, `in_ready[grant]`=`out_ready`, all other `in_ready`=0.
- LEN_HI: on transfer capture `len_hi`, go to LEN_LO. `out_sof`=`out_valid`.
- LEN_LO: on transfer, `remaining` ← {len_hi, byte}. If zero, go to IDLE and assert `out_eof` on this transfer; else go to BODY.
- BODY: on transfer decrement `remaining`; when `remaining`==1 at transfer, assert `out_eof` and go to IDLE.
- No preemption: a locked feed that drops `in_valid` mid-frame stalls the output (`out_valid`=0) indefinitely; other feeds wait.
- `remaining` is 16 bits unsigned; L=0xFFFF is legal (65 537 bytes total), with no overflow.
- `out_feed` = `grant`, held stable from the LEN_HI entry through the eof transfer, and retained in IDLE.

## Timing
- Reset values: state IDLE, `grant`=0, `last_grant`=NUM_FEEDS-1 (feed 0 wins first), `remaining`=0, `len_hi`=0. Therefore `in_ready`=0, `out_valid`=0, `out_sof`=0, `out_eof`=0, `busy`=0, `out_feed`=0.
- Data path latency is zero cycles (combinational) once locked. Arbitration overhead is exactly one idle cycle between frames.
- A frame of L bytes occupies L+3 cycles minimum (1 arbitration cycle + L+2 transfers).
- Reset asserted mid-frame: return to IDLE immediately (asynchronously). The partial frame is abandoned, and the downstream parser must be reset together with this block.
- A feed raising `in_valid` in the same cycle the lock ends does not participate until the next IDLE cycle.
- If the granted feed is the only requester, it is re-granted after the idle cycle.

## Structure
- Package `feed_arb_pkg`: state enum `arb_state_t` {IDLE, LEN_HI, LEN_LO, BODY}, constant `LEN_BYTES`=2.
- Sub-module `rr_pick`: combinational round-robin selector (request vector, last grant → found flag, next index). It is reusable by other schedulers.
- Top module: FSM, `remaining` counter, and the pass-through mux.

## Test plan
- Feed 0 alone sends 00 03 50 AA BB → output bytes 00 03 50 AA BB; `out_feed`=0; `out_sof` on 00; `out_eof` on BB; `busy` falls the next cycle.
- Feeds 0 and 2 continuously valid, each sending 3-byte frames (00 01 50) → grant order 0,2,0,2 with one idle cycle between frames.
- Feed 1 frame 00 00 (L=0) → two transfers; `out_eof` on the second 00; back to IDLE.
- Feed 3 drops `in_valid` for 5 cycles mid-body while feed 0 is requesting → `out_valid`=0 for 5 cycles; feed 0 is not granted until feed 3's eof.
- `out_ready` toggled low on alternate cycles during a frame 00 04 50 01 02 03 → no byte lost or duplicated; `in_ready[grant]` mirrors `out_ready`.
- `rst` pulsed during BODY of feed 2 → all `in_ready`=0 and `busy`=0 at once. After release, feed 0 is granted first when feeds 0 and 2 both request.

Source files
------------

// File: rtl/feed_arb_pkg.sv
// Shared types for the feed arbiter: FSM state encoding and frame-header size.
package feed_arb_pkg;
  typedef enum logic [1:0] {IDLE, LEN_HI, LEN_LO, BODY} arb_state_t;
  localparam int LEN_BYTES = 2;
endpackage

// File: rtl/feed_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after `last`, with wrap.
module rr_pick
  import feed_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  function automatic logic [W-1:0] wrap(input int v);
    return W'(v % N);
  endfunction

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Offsets 1..N so the previous winner is considered last.
    for (int i = 1; i <= N; i++) begin
      if (!found && req[wrap(int'(last) + i)]) begin
        found = 1'b1;
        idx   = wrap(int'(last) + i);
      end
    end
  end

endmodule

// File: rtl/feed_arbiter.sv
// Message-granular round-robin arbiter: locks one feed per length-prefixed frame
// and passes its bytes straight through to the single parser port.
module feed_arbiter
  import feed_arb_pkg::*;
#(
  parameter int NUM_FEEDS = 4,
  parameter int FEED_W    = $clog2(NUM_FEEDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_FEEDS*8-1:0] in_byte,
  input  logic [NUM_FEEDS-1:0]   in_valid,
  output logic [NUM_FEEDS-1:0]   in_ready,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FEED_W-1:0]      out_feed,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   busy
);

  arb_state_t        state;
  logic [FEED_W-1:0] grant;
  logic [FEED_W-1:0] last_grant;
  logic [15:0]       remaining;
  logic [7:0]        len_hi;
  logic [7:0]        feed_byte [NUM_FEEDS];
  logic              pick_found;
  logic [FEED_W-1:0] pick_idx;
  logic              xfer;
  logic              len_zero;

  for (genvar g = 0; g < NUM_FEEDS; g++) begin : g_split
    assign feed_byte[g] = in_byte[8*g +: 8];
  end

  rr_pick #(.N(NUM_FEEDS), .W(FEED_W)) u_pick (
    .req   (in_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    in_ready  = '0;
    out_byte  = feed_byte[grant];
    out_valid = 1'b0;
    if (state != IDLE) begin
      out_valid       = in_valid[grant];
      in_ready[grant] = out_ready;
    end
  end

  assign xfer     = out_valid && out_ready;
  assign len_zero = ({len_hi, out_byte} == 16'd0);
  assign out_sof  = (state == LEN_HI) && out_valid;
  assign out_eof  = out_valid && (((state == LEN_LO) && len_zero) ||
                                  ((state == BODY) && (remaining == 16'd1)));
  assign out_feed = grant;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= FEED_W'(NUM_FEEDS - 1);
      remaining  <= '0;
      len_hi     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant      <= pick_idx;
            last_grant <= pick_idx;
            state      <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_hi <= out_byte;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            remaining <= {len_hi, out_byte};
            state     <= len_zero ? IDLE : BODY;
          end
        end
        BODY: begin
          if (xfer) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feed_arbiter.sv
// Randomised scoreboard bench for feed_arbiter with a frame-level reference model.
module tb_feed_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*8-1:0] in_byte;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [7:0]     out_byte;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_feed;
  logic           out_sof;
  logic           out_eof;
  logic           busy;

  always #5 clk = ~clk;

  feed_arbiter #(.NUM_FEEDS(N), .FEED_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_feed  (out_feed),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy)
  );

  typedef logic [7:0] bq_t[$];
  typedef int iq_t[$];
  typedef struct {
    logic [7:0] b;
    int         f;
    bit         sof;
    bit         eof;
  } exp_t;

  logic [7:0] fq [N][$];
  exp_t       sb[$];
  exp_t       e_mon;
  int         sof_feeds[$];
  int         hold [N];
  int         vprob = 100;
  int         rprob = 100;
  int         rmode = 0;
  bit         alt = 1'b0;

  bit m_locked = 1'b0;
  int m_feed = 0;
  int m_last = N - 1;
  int m_left = 0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] rdy_exp();
    logic [N-1:0] r;
    r = '0;
    if (m_locked && out_ready) r[m_feed] = 1'b1;
    return r;
  endfunction

  // Reference: whole frames are granted round-robin; a frame is L+2 transfers.
  task automatic model_edge();
    if (m_locked) begin
      if (in_valid[m_feed] && out_ready) begin
        void'(fq[m_feed].pop_front());
        m_left--;
        if (m_left == 0) m_locked = 1'b0;
      end
    end else if (in_valid != '0) begin
      int p;
      int len;
      p = -1;
      for (int k = 1; k <= N; k++) begin
        if (p < 0 && in_valid[(m_last + k) % N]) p = (m_last + k) % N;
      end
      m_feed   = p;
      m_last   = p;
      m_locked = 1'b1;
      len      = int'({fq[p][0], fq[p][1]});
      m_left   = len + 2;
      for (int k = 0; k < len + 2; k++)
        sb.push_back('{b: fq[p][k], f: p, sof: (k == 0), eof: (k == len + 1)});
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hold[i] > 0) begin
        hold[i]--;
        in_valid[i] = 1'b0;
      end else begin
        in_valid[i] = (fq[i].size() > 0) && (int'($urandom_range(99)) < vprob);
      end
      in_byte[i*8 +: 8] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
    case (rmode)
      1:       out_ready = (int'($urandom_range(99)) < rprob);
      2:       begin alt = ~alt; out_ready = alt; end
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    drive();
  endtask

  function automatic bit pending();
    bit any;
    any = m_locked || (sb.size() != 0);
    for (int i = 0; i < N; i++) if (fq[i].size() != 0 || hold[i] != 0) any = 1'b1;
    return any;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 1, 0);
  endtask

  task automatic add_bytes(input int f, input bq_t b);
    foreach (b[k]) fq[f].push_back(b[k]);
  endtask

  task automatic add_rand(input int f, input int len);
    fq[f].push_back(8'(len >> 8));
    fq[f].push_back(8'(len));
    for (int k = 0; k < len; k++) fq[f].push_back(8'($urandom_range(255)));
  endtask

  task automatic check_order(input string name, input iq_t exp);
    chk({name, "_count"}, sof_feeds.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sof_feeds.size(); i++)
      chk({name, "_grant"}, sof_feeds[i], exp[i]);
    sof_feeds.delete();
  endtask

  // Monitor: per-cycle control checks plus scoreboard pop on every transfer.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("busy", int'(busy), int'(m_locked));
      chk("out_feed", int'(out_feed), m_feed);
      chk("out_valid", int'(out_valid), int'(m_locked && in_valid[m_feed]));
      chk("in_ready", int'(in_ready), int'(rdy_exp()));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          chk("out_byte", int'(out_byte), int'(e_mon.b));
          chk("xfer_feed", int'(out_feed), e_mon.f);
          chk("out_sof", int'(out_sof), int'(e_mon.sof));
          chk("out_eof", int'(out_eof), int'(e_mon.eof));
        end
        if (out_sof) sof_feeds.push_back(int'(out_feed));
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_byte = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) hold[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_sof", int'(out_sof), 0);
    chk("reset_eof", int'(out_eof), 0);
    chk("reset_out_feed", int'(out_feed), 0);
    rst = 1'b0;

    // Two continuously-valid feeds alternate frame by frame.
    add_bytes(0, '{8'h00, 8'h01, 8'h50, 8'h00, 8'h01, 8'h50});
    add_bytes(2, '{8'h00, 8'h01, 8'h50, 8'h00, 8'h01, 8'h50});
    drain(200);
    check_order("alternate", '{0, 2, 0, 2});

    add_bytes(0, '{8'h00, 8'h03, 8'h50, 8'hAA, 8'hBB});
    drain(200);
    check_order("single", '{0});

    add_bytes(1, '{8'h00, 8'h00});
    drain(200);
    check_order("zero_len", '{1});

    // Locked feed stalls mid-body while another feed waits.
    add_bytes(3, '{8'h00, 8'h06, 8'h50, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    repeat (4) step();
    add_bytes(0, '{8'h00, 8'h01, 8'h50});
    hold[3] = 5;
    drain(200);
    check_order("stall", '{3, 0});

    rmode = 2;
    add_bytes(1, '{8'h00, 8'h04, 8'h50, 8'h01, 8'h02, 8'h03});
    drain(200);
    check_order("backpressure", '{1});
    rmode = 0;

    // Asynchronous reset in the middle of a body.
    add_rand(2, 6);
    repeat (5) step();
    chk("pre_reset_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    in_valid = '0;
    for (int k = 0; k < m_left; k++) void'(fq[m_feed].pop_front());
    m_locked = 1'b0;
    m_feed = 0;
    m_last = N - 1;
    m_left = 0;
    sb.delete();
    sof_feeds.delete();
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    #2;
    rst = 1'b0;
    add_bytes(0, '{8'h00, 8'h01, 8'h50});
    add_bytes(2, '{8'h00, 8'h01, 8'h50});
    drain(200);
    check_order("after_reset", '{0, 2});

    vprob = 75;
    rprob = 70;
    rmode = 1;
    for (int i = 0; i < 40; i++) add_rand(int'($urandom_range(N - 1)), int'($urandom_range(7)));
    add_rand(3, 16'h0102);
    drain(20000);
    sof_feeds.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
